reg_file: RTL and testbench

- 32-entry, XLEN-wide integer register file for the RISC-V core.
- Sits directly downstream of the writeback-select 2:1 multiplexer. It consumes the mux output as write data, and its two read ports feed the ALU operand path.
- Two combinational read ports and one synchronous write port.
- x0 is hardwired to zero.

---
 rtl/rv_pkg.sv | 27 ++
 rtl/reg_file_if.sv | 35 +++
 rtl/reg_file_rf_read_port.sv | 55 +++++
 rtl/reg_file.sv | 106 ++++++++++
 tb/tb_reg_file.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared constants and types for the RISC-V integer datapath.
//   XLEN      : integer register width
//   REG_AW    : register address width
//   NREG      : number of architectural integer registers
//   ZERO_REG  : address of the hardwired-zero register x0
//   word_t    : one XLEN-wide data word
//   reg_addr_t: one register address
//   sat_inc16 : 16-bit increment that sticks at all-ones
// ----------------------------------------------------------------------------
package rv_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREG   = 32;

   typedef logic [XLEN-1:0]   word_t;
   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

   function automatic logic [15:0] sat_inc16(input logic [15:0] i_val);
      return (i_val == 16'hFFFF) ? i_val : i_val + 16'd1;
   endfunction

endpackage : rv_pkg

// File: rtl/reg_file_if.sv
// ----------------------------------------------------------------------------
// reg_file_if
// Bus between the core pipeline (master) and the integer register file
// (slave).
//   rs1_addr/rs2_addr : read port addresses         (master -> slave)
//   rs1_data/rs2_data : read port data              (slave  -> master)
//   rd_we/rd_addr     : write enable and address    (master -> slave)
//   rd_data           : write data, writeback mux   (master -> slave)
//   wr_count          : saturating committed-write count (slave -> master)
// ----------------------------------------------------------------------------
interface reg_file_if #(
   parameter int XLEN = rv_pkg::XLEN,
   parameter int AW   = rv_pkg::REG_AW
);

   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rd_we;
   logic [AW-1:0]   rd_addr;
   logic [XLEN-1:0] rd_data;
   logic [15:0]     wr_count;

   modport master (
      output rs1_addr, rs2_addr, rd_we, rd_addr, rd_data,
      input  rs1_data, rs2_data, wr_count
   );

   modport slave (
      input  rs1_addr, rs2_addr, rd_we, rd_addr, rd_data,
      output rs1_data, rs2_data, wr_count
   );

endinterface : reg_file_if

// File: rtl/reg_file_rf_read_port.sv
// ----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the integer register file: selects a word
// from the flattened register image, forces x0 (and any unimplemented
// address) to zero and, when RF_BYPASS_EN is defined, forwards the write
// data that is being committed to the same address this cycle.
//   i_regs    : register image, entry 0 is a constant zero
//   i_addr    : read address
//   i_wr_en   : write is being committed this cycle  (RF_BYPASS_EN only)
//   i_wr_addr : write address                        (RF_BYPASS_EN only)
//   i_wr_data : write data                           (RF_BYPASS_EN only)
//   o_data    : read data
// Build option: RF_BYPASS_EN selects write-first forwarding.
// ----------------------------------------------------------------------------
module rf_read_port #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic [NREG-1:0][XLEN-1:0] i_regs,
   input  logic [AW-1:0]             i_addr,
`ifdef RF_BYPASS_EN
   input  logic                      i_wr_en,
   input  logic [AW-1:0]             i_wr_addr,
   input  logic [XLEN-1:0]           i_wr_data,
`endif
   output logic [XLEN-1:0]           o_data
);

   import rv_pkg::*;

   logic w_addr_ok;

   // Only a partially populated address space needs a range check.
   if (NREG < (1 << AW)) begin : g_partial
      assign w_addr_ok = (i_addr < AW'(NREG));
   end else begin : g_full
      assign w_addr_ok = 1'b1;
   end

   // NOTE: o_data gets a default before any condition so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      o_data = '0;
      if ((i_addr != AW'(ZERO_REG)) && w_addr_ok) begin
         o_data = i_regs[i_addr];
      end
`ifdef RF_BYPASS_EN
      if (i_wr_en && (i_wr_addr != AW'(ZERO_REG)) && (i_wr_addr == i_addr)) begin
         o_data = i_wr_data;
      end
`endif
   end

endmodule : rf_read_port

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// 32 x XLEN integer register file: two combinational read ports and one
// synchronous write port; x0 is a constant zero and is never stored.
//   clk   : core clock, state updates on the rising edge
//   rst_n : asynchronous active-low reset, clears x1..x(NREG-1) and wr_count
//   bus   : reg_file_if.slave (read ports, write port, wr_count)
// Build option: RF_BYPASS_EN makes reads of the address being written return
// the new data in the same cycle; without it the old value is returned.
// ----------------------------------------------------------------------------
module reg_file #(
   parameter int XLEN = rv_pkg::XLEN,
   parameter int NREG = rv_pkg::NREG,
   parameter int AW   = rv_pkg::REG_AW
) (
   input  logic      clk,
   input  logic      rst_n,
   reg_file_if.slave bus
);

   import rv_pkg::*;

   logic [NREG-1:1][XLEN-1:0] r_regs;
   logic [NREG-1:0][XLEN-1:0] w_regs;
   logic [15:0]               r_wr_count;
   logic                      r_armed;
   logic                      w_addr_ok;
   logic                      w_commit;

   if (NREG < (1 << AW)) begin : g_partial
      assign w_addr_ok = (bus.rd_addr < AW'(NREG));
   end else begin : g_full
      assign w_addr_ok = 1'b1;
   end

   // The first rising edge after reset release only arms the write port, so
   // a write presented on the release edge can never slip into the array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
      end else begin
         r_armed <= 1'b1;
      end
   end

   assign w_commit = r_armed && bus.rd_we && w_addr_ok &&
                     (bus.rd_addr != AW'(ZERO_REG));

   // NOTE: the array itself is reset because software may read any register
   // right after reset and must see zero; this rules out a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regs <= '0;
      end else if (w_commit) begin
         // NOTE: non-blocking so same-edge readers of r_regs see the old value.
         r_regs[bus.rd_addr] <= bus.rd_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_count <= '0;
      end else if (w_commit) begin
         r_wr_count <= sat_inc16(r_wr_count);
      end
   end

   assign bus.wr_count = r_wr_count;

   // Read image with x0 as a constant zero rather than a stored word.
   always_comb begin
      w_regs            = '0;
      w_regs[NREG-1:1]  = r_regs;
   end

   rf_read_port #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
   ) u_rd1 (
      .i_regs    (w_regs),
      .i_addr    (bus.rs1_addr),
`ifdef RF_BYPASS_EN
      .i_wr_en   (w_commit),
      .i_wr_addr (bus.rd_addr),
      .i_wr_data (bus.rd_data),
`endif
      .o_data    (bus.rs1_data)
   );

   rf_read_port #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
   ) u_rd2 (
      .i_regs    (w_regs),
      .i_addr    (bus.rs2_addr),
`ifdef RF_BYPASS_EN
      .i_wr_en   (w_commit),
      .i_wr_addr (bus.rd_addr),
      .i_wr_data (bus.rd_data),
`endif
      .o_data    (bus.rs2_data)
   );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file
// Directed bench for reg_file: reset, write/readback, x0 immunity,
// same-cycle read/write, asynchronous reset mid-write and wr_count
// saturation. Inputs change on the falling edge; outputs are sampled 1 ns
// after an input change, away from the rising edge.
// ----------------------------------------------------------------------------
module tb_reg_file;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

`ifdef RF_BYPASS_EN
   localparam logic [31:0] SAME_CYCLE_X7 = 32'h0000_0002;
`else
   localparam logic [31:0] SAME_CYCLE_X7 = 32'h0000_0001;
`endif

   reg_file_if bus ();

   reg_file u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Present one write for a single rising edge, return on the next falling
   // edge with the write removed.
   task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.rd_we   = 1'b1;
      bus.rd_addr = addr;
      bus.rd_data = data;
      @(negedge clk);
      bus.rd_we   = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.rs1_addr = '0;
      bus.rs2_addr = '0;
      bus.rd_we    = 1'b0;
      bus.rd_addr  = '0;
      bus.rd_data  = '0;

      // 1. reset held through an edge, released mid-cycle, all reads zero
      #12;
      bus.rs1_addr = 5'd5;
      #1;
      check("rst_hold_rs1", bus.rs1_data, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         bus.rs1_addr = 5'(i);
         bus.rs2_addr = 5'(31 - i);
         #1;
         check($sformatf("rst_rs1_x%0d", i), bus.rs1_data, 32'h0);
         check($sformatf("rst_rs2_x%0d", 31 - i), bus.rs2_data, 32'h0);
      end
      check("rst_wr_count", {16'h0, bus.wr_count}, 32'h0);

      // 2. writes on consecutive edges, then readback on both ports
      @(negedge clk);
      bus.rd_we   = 1'b1;
      bus.rd_addr = 5'd5;
      bus.rd_data = 32'h0000_ffff;
      @(negedge clk);
      bus.rd_addr = 5'd6;
      bus.rd_data = 32'haaaa_0000;
      @(negedge clk);
      bus.rd_we    = 1'b0;
      bus.rs1_addr = 5'd5;
      bus.rs2_addr = 5'd6;
      #1;
      check("wr_x5", bus.rs1_data, 32'h0000_ffff);
      check("wr_x6", bus.rs2_data, 32'haaaa_0000);
      check("wr_count_2", {16'h0, bus.wr_count}, 32'd2);
      bus.rs2_addr = 5'd5;
      #1;
      check("same_addr_rs2", bus.rs2_data, 32'h0000_ffff);

      // 3. write to x0 is discarded and never forwarded
      @(negedge clk);
      bus.rd_we    = 1'b1;
      bus.rd_addr  = 5'd0;
      bus.rd_data  = 32'hdead_beef;
      bus.rs1_addr = 5'd0;
      bus.rs2_addr = 5'd0;
      #1;
      check("x0_same_cycle", bus.rs1_data, 32'h0);
      @(negedge clk);
      bus.rd_we = 1'b0;
      #1;
      check("x0_rs1", bus.rs1_data, 32'h0);
      check("x0_rs2", bus.rs2_data, 32'h0);
      check("x0_wr_count", {16'h0, bus.wr_count}, 32'd2);

      // 4. same-cycle read/write of x7 (old 1, new 2)
      write_reg(5'd7, 32'h1);
      bus.rd_we    = 1'b1;
      bus.rd_addr  = 5'd7;
      bus.rd_data  = 32'h2;
      bus.rs1_addr = 5'd7;
      bus.rs2_addr = 5'd7;
      #1;
      check("raw_x7_rs1", bus.rs1_data, SAME_CYCLE_X7);
      check("raw_x7_rs2", bus.rs2_data, SAME_CYCLE_X7);
      @(negedge clk);
      bus.rd_we = 1'b0;
      #1;
      check("raw_x7_after_rs1", bus.rs1_data, 32'h2);
      check("raw_x7_after_rs2", bus.rs2_data, 32'h2);
      check("raw_wr_count", {16'h0, bus.wr_count}, 32'd4);

      // 5. asynchronous reset between edges, write at release edge dropped
      write_reg(5'd9, 32'h1234_5678);
      bus.rs1_addr = 5'd9;
      #1;
      check("x9_before_rst", bus.rs1_data, 32'h1234_5678);
      #2;
      rst_n = 1'b0;
      #1;
      check("x9_async_rst", bus.rs1_data, 32'h0);
      check("rst_clears_count", {16'h0, bus.wr_count}, 32'h0);
      bus.rd_we   = 1'b1;
      bus.rd_addr = 5'd9;
      bus.rd_data = 32'hcafe_f00d;
      @(posedge clk);
      #1;
      check("write_in_rst", bus.rs1_data, 32'h0);
      @(posedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.rd_we = 1'b0;
      #1;
      check("release_edge_write", bus.rs1_data, 32'h0);
      check("release_edge_count", {16'h0, bus.wr_count}, 32'h0);
      write_reg(5'd9, 32'h0000_0055);
      #1;
      check("x9_after_release", bus.rs1_data, 32'h0000_0055);
      check("count_after_release", {16'h0, bus.wr_count}, 32'd1);

      // 6. wr_count saturation with 65,540 writes to x1 from a clean reset
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("sat_start_count", {16'h0, bus.wr_count}, 32'h0);
      for (int i = 1; i <= 65540; i++) begin
         @(negedge clk);
         if (i == 65535) check("count_fffe", {16'h0, bus.wr_count}, 32'h0000_fffe);
         if (i == 65537) check("count_no_wrap", {16'h0, bus.wr_count}, 32'h0000_ffff);
         bus.rd_we   = 1'b1;
         bus.rd_addr = 5'd1;
         bus.rd_data = 32'(i);
      end
      @(negedge clk);
      bus.rd_we    = 1'b0;
      bus.rs1_addr = 5'd1;
      #1;
      check("count_sat", {16'h0, bus.wr_count}, 32'h0000_ffff);
      check("x1_last", bus.rs1_data, 32'h0001_0004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_reg_file
